// File: rtl/vend_sequencer_if.sv
// ============================================================================
// Module : vend_sequencer_if
// Coin, selection, dispense and change-hopper signals of the vending sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface vend_sequencer_if #(
    parameter int CREDIT_W = 6
);
    logic [1:0]          in;
    logic                sel_valid;
    logic [1:0]          sel;
    logic                cancel;
    logic [3:0]          sold_out;
    logic                disp_ack;
    logic                chg_ack;
    logic                disp_req;
    logic [1:0]          disp_item;
    logic                chg_req;
    logic [1:0]          chg_coin;
    logic [CREDIT_W-1:0] credit;
    logic                coin_reject;
    logic                sel_error;
    logic                fault;
    logic                busy;

    modport master (
        output in, sel_valid, sel, cancel, sold_out, disp_ack, chg_ack,
        input  disp_req, disp_item, chg_req, chg_coin, credit,
               coin_reject, sel_error, fault, busy
    );

    modport slave (
        input  in, sel_valid, sel, cancel, sold_out, disp_ack, chg_ack,
        output disp_req, disp_item, chg_req, chg_coin, credit,
               coin_reject, sel_error, fault, busy
    );
endinterface

`default_nettype wire

// File: rtl/vend_sequencer.sv
// ============================================================================
// Module : vend_sequencer
// Vending-machine sequencer: credit, selection, dispense handshake, change payout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vend_sequencer #(
    parameter int CREDIT_W   = 6,
    parameter int MAX_CREDIT = 40,
    parameter int PRICE0     = 3,
    parameter int PRICE1     = 4,
    parameter int PRICE2     = 5,
    parameter int PRICE3     = 7,
    parameter int TIMEOUT    = 255
) (
    input  wire logic       clk,
    input  wire logic       rst,
    vend_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    localparam logic [7:0]        C_TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [CREDIT_W:0] C_MAX_CREDIT   = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              r_state,       w_state_nxt;
    logic [CREDIT_W-1:0] r_credit,      w_credit_nxt;
    logic                r_disp_req,    w_disp_req_nxt;
    logic [1:0]          r_disp_item,   w_disp_item_nxt;
    logic                r_chg_req,     w_chg_req_nxt;
    logic [1:0]          r_chg_coin,    w_chg_coin_nxt;
    logic [7:0]          r_timer,       w_timer_nxt;
    logic                r_coin_reject, w_coin_reject_nxt;
    logic                r_sel_error,   w_sel_error_nxt;
    logic                r_fault,       w_fault_nxt;
    logic                r_busy;

    logic [CREDIT_W:0]   w_coin_val;
    logic [CREDIT_W:0]   w_coin_sum;
    logic                w_coin_ok;
    logic                w_coin_bad;
    logic [CREDIT_W-1:0] w_eff;
    logic [CREDIT_W-1:0] w_sel_price;
    logic [CREDIT_W-1:0] w_item_price;
    logic                w_sel_ok;
    logic [CREDIT_W-1:0] w_chg_val;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = CREDIT_W'(PRICE0);
            2'd1:    price_of = CREDIT_W'(PRICE1);
            2'd2:    price_of = CREDIT_W'(PRICE2);
            default: price_of = CREDIT_W'(PRICE3);
        endcase
    endfunction

    // Largest coin first when paying back change.
    function automatic logic [1:0] coin_for(input logic [CREDIT_W-1:0] amt);
        coin_for = (amt >= CREDIT_W'(2)) ? 2'b10 : 2'b01;
    endfunction

    always_comb begin
        w_coin_val   = (bus.in == 2'b01) ? (CREDIT_W+1)'(1) :
                       (bus.in == 2'b10) ? (CREDIT_W+1)'(2) : '0;
        w_coin_sum   = {1'b0, r_credit} + w_coin_val;
        w_coin_ok    = (w_coin_val != '0) && (w_coin_sum <= C_MAX_CREDIT);
        w_coin_bad   = (bus.in != 2'b00) && !w_coin_ok;
        w_eff        = w_coin_ok ? w_coin_sum[CREDIT_W-1:0] : r_credit;
        w_sel_price  = price_of(bus.sel);
        w_item_price = price_of(r_disp_item);
        w_sel_ok     = !bus.sold_out[bus.sel] && (w_eff >= w_sel_price);
        w_chg_val    = (r_chg_coin == 2'b10) ? CREDIT_W'(2) : CREDIT_W'(1);
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_disp_req_nxt    = r_disp_req;
        w_disp_item_nxt   = r_disp_item;
        w_chg_req_nxt     = r_chg_req;
        w_chg_coin_nxt    = r_chg_coin;
        w_timer_nxt       = r_timer;
        w_coin_reject_nxt = 1'b0;
        w_sel_error_nxt   = 1'b0;
        w_fault_nxt       = 1'b0;

        case (r_state)
            S_IDLE, S_CREDIT: begin
                w_coin_reject_nxt = w_coin_bad;
                w_credit_nxt      = w_eff;
                w_state_nxt       = (w_eff != '0) ? S_CREDIT : S_IDLE;
                if (r_state == S_CREDIT && bus.cancel) begin
                    w_state_nxt    = S_CHANGE;
                    w_chg_req_nxt  = 1'b1;
                    w_chg_coin_nxt = coin_for(w_eff);
                end else if (bus.sel_valid) begin
                    if (r_state == S_CREDIT && w_sel_ok) begin
                        w_credit_nxt    = w_eff - w_sel_price;
                        w_disp_req_nxt  = 1'b1;
                        w_disp_item_nxt = bus.sel;
                        w_timer_nxt     = '0;
                        w_state_nxt     = S_DISPENSE;
                    end else begin
                        w_sel_error_nxt = 1'b1;
                    end
                end
            end

            S_DISPENSE: begin
                w_coin_reject_nxt = (bus.in != 2'b00);
                // An acknowledge on the timeout cycle still counts as a successful vend.
                if (bus.disp_ack) begin
                    w_disp_req_nxt = 1'b0;
                    if (r_credit != '0) begin
                        w_state_nxt    = S_CHANGE;
                        w_chg_req_nxt  = 1'b1;
                        w_chg_coin_nxt = coin_for(r_credit);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_timer == C_TIMEOUT_LAST) begin
                    w_disp_req_nxt = 1'b0;
                    w_fault_nxt    = 1'b1;
                    w_credit_nxt   = r_credit + w_item_price;
                    w_state_nxt    = S_CHANGE;
                    w_chg_req_nxt  = 1'b1;
                    w_chg_coin_nxt = coin_for(r_credit + w_item_price);
                end else begin
                    w_timer_nxt = r_timer + 8'd1;
                end
            end

            S_CHANGE: begin
                w_coin_reject_nxt = (bus.in != 2'b00);
                if (bus.chg_ack && r_chg_req) begin
                    w_credit_nxt = r_credit - w_chg_val;
                    if (r_credit == w_chg_val) begin
                        w_chg_req_nxt  = 1'b0;
                        w_chg_coin_nxt = 2'b00;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_chg_coin_nxt = coin_for(r_credit - w_chg_val);
                    end
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_disp_req    <= 1'b0;
            r_disp_item   <= 2'b00;
            r_chg_req     <= 1'b0;
            r_chg_coin    <= 2'b00;
            r_timer       <= '0;
            r_coin_reject <= 1'b0;
            r_sel_error   <= 1'b0;
            r_fault       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_disp_req    <= w_disp_req_nxt;
            r_disp_item   <= w_disp_item_nxt;
            r_chg_req     <= w_chg_req_nxt;
            r_chg_coin    <= w_chg_coin_nxt;
            r_timer       <= w_timer_nxt;
            r_coin_reject <= w_coin_reject_nxt;
            r_sel_error   <= w_sel_error_nxt;
            r_fault       <= w_fault_nxt;
            r_busy        <= (w_state_nxt == S_DISPENSE) || (w_state_nxt == S_CHANGE);
        end
    end

    assign bus.credit      = r_credit;
    assign bus.disp_req    = r_disp_req;
    assign bus.disp_item   = r_disp_item;
    assign bus.chg_req     = r_chg_req;
    assign bus.chg_coin    = r_chg_coin;
    assign bus.coin_reject = r_coin_reject;
    assign bus.sel_error   = r_sel_error;
    assign bus.fault       = r_fault;
    assign bus.busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_vend_sequencer.sv
// ============================================================================
// Module : tb_vend_sequencer
// Directed bench for vend_sequencer with a credit-level reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_vend_sequencer;

    localparam int CW   = 6;
    localparam int MAXC = 40;
    localparam int TMO  = 255;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vend_sequencer_if #(.CREDIT_W(CW)) bus ();

    vend_sequencer #(
        .CREDIT_W(CW), .MAX_CREDIT(MAXC), .PRICE0(3), .PRICE1(4),
        .PRICE2(5), .PRICE3(7), .TIMEOUT(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int price(input int i);
        case (i)
            0:       return 3;
            1:       return 4;
            2:       return 5;
            default: return 7;
        endcase
    endfunction

    // Reference: the machine is either vending, paying change, or holding credit.
    int m_credit, m_item, m_wait;
    bit m_vending, m_paying, m_rej, m_serr, m_fault;
    int mv, meff;
    bit mok;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_credit = 0; m_item = 0; m_wait = 0;
            m_vending = 0; m_paying = 0; m_rej = 0; m_serr = 0; m_fault = 0;
        end else begin
            m_rej = 0; m_serr = 0; m_fault = 0;
            mv  = (bus.in == 2'b01) ? 1 : (bus.in == 2'b10) ? 2 : 0;
            if (m_vending) begin
                m_rej = (bus.in != 0);
                if (bus.disp_ack) begin
                    m_vending = 0;
                    m_paying  = (m_credit > 0);
                end else begin
                    m_wait++;
                    if (m_wait == TMO) begin
                        m_fault   = 1;
                        m_credit += price(m_item);
                        m_vending = 0;
                        m_paying  = 1;
                    end
                end
            end else if (m_paying) begin
                m_rej = (bus.in != 0);
                if (bus.chg_ack) begin
                    m_credit -= (m_credit >= 2) ? 2 : 1;
                    if (m_credit == 0) m_paying = 0;
                end
            end else begin
                mok   = (mv > 0) && (m_credit + mv <= MAXC);
                m_rej = (bus.in != 0) && !mok;
                meff  = m_credit + (mok ? mv : 0);
                if (m_credit > 0 && bus.cancel) begin
                    m_credit = meff;
                    m_paying = 1;
                end else if (bus.sel_valid && !bus.sold_out[bus.sel] && meff >= price(int'(bus.sel))) begin
                    m_credit  = meff - price(int'(bus.sel));
                    m_item    = int'(bus.sel);
                    m_wait    = 0;
                    m_vending = 1;
                end else begin
                    m_serr   = bus.sel_valid;
                    m_credit = meff;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("credit", bus.credit, m_credit);
        check("disp_req", bus.disp_req, m_vending);
        if (m_vending) check("disp_item", bus.disp_item, m_item);
        check("chg_req", bus.chg_req, m_paying);
        if (m_paying) check("chg_coin", bus.chg_coin, (m_credit >= 2) ? 2 : 1);
        check("coin_reject", bus.coin_reject, m_rej);
        check("sel_error", bus.sel_error, m_serr);
        check("fault", bus.fault, m_fault);
        check("busy", bus.busy, m_vending || m_paying);
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] c);
        bus.in = c; cyc; bus.in = 2'b00;
    endtask

    task automatic select(input logic [1:0] s);
        bus.sel = s; bus.sel_valid = 1'b1; cyc; bus.sel_valid = 1'b0;
    endtask

    task automatic do_cancel;
        bus.cancel = 1'b1; cyc; bus.cancel = 1'b0;
    endtask

    task automatic ack_disp;
        bus.disp_ack = 1'b1; cyc; bus.disp_ack = 1'b0;
    endtask

    // Acknowledge every change coin; returns the coin sequence as decimal digits.
    task automatic pay_out(output longint seq);
        seq = 0;
        for (int i = 0; i < 40 && bus.chg_req; i++) begin
            seq = seq * 10 + longint'(bus.chg_coin);
            bus.chg_ack = 1'b1; cyc; bus.chg_ack = 1'b0;
            cyc;
        end
        check("payout_done", bus.chg_req, 0);
    endtask

    longint seq;
    int     n;

    initial begin
        bus.in = 2'b00; bus.sel_valid = 1'b0; bus.sel = 2'b00; bus.cancel = 1'b0;
        bus.sold_out = 4'b0000; bus.disp_ack = 1'b0; bus.chg_ack = 1'b0;

        repeat (3) cyc;
        check("rst_outputs", {bus.disp_req, bus.disp_item, bus.chg_req, bus.chg_coin,
                              bus.coin_reject, bus.sel_error, bus.fault, bus.busy}, 0);
        check("rst_credit", bus.credit, 0);
        rst = 1'b1;
        cyc;

        do_cancel;
        check("idle_cancel", bus.chg_req, 0);

        // Exact-price vend, no change.
        coin(2'b10); coin(2'b10); coin(2'b01);
        check("credit5", bus.credit, 5);
        select(2'd2);
        check("vend_req", bus.disp_req, 1);
        check("vend_item", bus.disp_item, 2);
        check("vend_credit", bus.credit, 0);
        ack_disp;
        check("vend_done", {bus.disp_req, bus.chg_req, bus.busy}, 0);

        // Vend with change 5 -> 2,2,1.
        repeat (4) coin(2'b10);
        check("credit8", bus.credit, 8);
        select(2'd0);
        check("credit_after_sel0", bus.credit, 5);
        ack_disp;
        check("chg_start", bus.chg_req, 1);
        pay_out(seq);
        check("change_5", 32'(seq), 221);
        check("change_5_credit", bus.credit, 0);

        // Refused selections and invalid coin.
        coin(2'b10);
        select(2'd3);
        check("sel_err_price", bus.sel_error, 1);
        check("sel_err_credit", bus.credit, 2);
        repeat (3) coin(2'b10);
        bus.sold_out = 4'b0010;
        select(2'd1);
        check("sel_err_soldout", bus.sel_error, 1);
        check("soldout_credit", bus.credit, 8);
        bus.sold_out = 4'b0000;
        coin(2'b11);
        check("reject_11", bus.coin_reject, 1);
        do_cancel;
        pay_out(seq);
        check("cancel_change", 32'(seq), 2222);

        // Credit ceiling.
        repeat (19) coin(2'b10);
        coin(2'b01);
        check("credit39", bus.credit, 39);
        coin(2'b10);
        check("reject_over", bus.coin_reject, 1);
        check("over_credit", bus.credit, 39);
        coin(2'b01);
        check("credit40", bus.credit, 40);
        coin(2'b01);
        check("reject_41", bus.coin_reject, 1);
        select(2'd3);
        check("credit33", bus.credit, 33);
        coin(2'b01);
        check("reject_busy", bus.coin_reject, 1);
        check("busy_credit", bus.credit, 33);
        ack_disp;
        pay_out(seq);

        // Dispense timeout refunds the price.
        repeat (3) coin(2'b10);
        select(2'd1);
        check("to_credit2", bus.credit, 2);
        n = 0;
        while (!bus.fault && n < 300) begin cyc; n++; end
        check("timeout_cycles", n, TMO);
        check("timeout_credit", bus.credit, 6);
        check("timeout_req", bus.disp_req, 0);
        pay_out(seq);
        check("timeout_change", 32'(seq), 222);

        // Acknowledge on the timeout cycle wins.
        repeat (3) coin(2'b10);
        select(2'd1);
        repeat (TMO - 1) cyc;
        ack_disp;
        check("ack_wins_fault", bus.fault, 0);
        check("ack_wins_credit", bus.credit, 2);
        pay_out(seq);
        check("ack_wins_change", 32'(seq), 2);

        // Asynchronous reset in the middle of change.
        coin(2'b10); coin(2'b10);
        do_cancel;
        bus.chg_ack = 1'b1; cyc; bus.chg_ack = 1'b0;
        check("mid_chg_credit", bus.credit, 2);
        rst = 1'b0;
        #1;
        check("async_rst", {bus.chg_req, bus.busy, bus.credit}, 0);
        cyc;
        rst = 1'b1;
        cyc;
        select(2'd0);
        check("post_rst_idle", bus.sel_error, 1);
        coin(2'b01);
        check("post_rst_credit", bus.credit, 1);
        do_cancel;
        pay_out(seq);
        check("post_rst_change", 32'(seq), 1);

        repeat (2) cyc;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
Top-level sequencer for the coin-operated vending machine. It accumulates coin credit and validates item selections against per-item prices and sold-out flags. It drives a dispense handshake to the motor driver and pays back change one coin at a time through a handshake to the coin hopper. It uses the same 2-bit coin encoding as the coin-acceptor FSM: 00 none, 01 = 1 unit, 10 = 2 units, 11 invalid.

Parameters:
CREDIT_W, 6, width of credit register in units
MAX_CREDIT, 40, highest credit accepted; coins that would exceed it are rejected
PRICE0, 3, price of item 0 in units
PRICE1, 4, price of item 1 in units
PRICE2, 5, price of item 2 in units
PRICE3, 7, price of item 3 in units
TIMEOUT, 255, cycles to wait for disp_ack before refunding (8-bit counter)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
in  in  2  coin strobe, one cycle per coin; 01 = 1 unit, 10 = 2 units, 11 invalid
sel_valid  in  1  one-cycle selection strobe
sel  in  2  selected item index
cancel  in  1  one-cycle request to return all credit
sold_out  in  4  per-item empty flags, level
disp_ack  in  1  motor driver done, one-cycle pulse
chg_ack  in  1  hopper has ejected the requested coin, one-cycle pulse
disp_req  out  1  dispense request, level
disp_item  out  2  item being dispensed, stable while disp_req=1
chg_req  out  1  change coin request, level
chg_coin  out  2  coin to eject (01 or 10), stable while chg_req=1
credit  out  CREDIT_W  current credit
coin_reject  out  1  one-cycle pulse: coin refused
sel_error  out  1  one-cycle pulse: selection refused
fault  out  1  one-cycle pulse: dispense timed out
busy  out  1  high in DISPENSE or CHANGE

Behaviour:
- All outputs are registered. While rst=0, every output is 0 and state is IDLE.
- States: IDLE (credit=0), CREDIT, DISPENSE, CHANGE.
- Coin handling in IDLE/CREDIT:
  - A valid coin with credit+value <= MAX_CREDIT updates credit the next cycle; IDLE goes to CREDIT.
  - A coin of 11, or one that would exceed MAX_CREDIT, gives coin_reject=1 next cycle; credit unchanged.
- Coin in DISPENSE/CHANGE: always rejected with coin_reject pulse.
- CREDIT priority, highest first:
  1. cancel: go to CHANGE with current credit; a same-cycle sel_valid is ignored, with no sel_error.
  2. sel_valid: evaluated against credit plus any coin accepted in the same cycle.
     - If sold_out[sel]=1 or effective credit < PRICE[sel]: sel_error pulse, stay in CREDIT.
     - Otherwise: credit <= effective credit - PRICE[sel], disp_item <= sel, disp_req <= 1, go to DISPENSE.
- sel_valid or cancel in IDLE: no credit, so sel_error pulse on sel_valid; cancel is ignored.
- DISPENSE:
  - disp_req is held until disp_ack. On ack, disp_req=0 next cycle, and state goes to CHANGE if credit>0, else IDLE.
  - Timeout counter resets on entry. If TIMEOUT cycles pass with no ack: disp_req=0, credit += PRICE[disp_item], fault pulse, go to CHANGE.
  - An ack arriving in the same cycle as the timeout wins; no fault.
  - sel_valid/cancel are ignored with no error pulse.
- CHANGE:
  - chg_req=1 with chg_coin=10 if credit>=2, else 01.
  - On chg_ack, credit decreases by the coin value the next cycle and chg_coin is recomputed.
  - chg_req stays high while credit>0. When credit reaches 0, chg_req=0 and state goes to IDLE.
  - chg_ack while chg_req=0 is ignored.
- Credit never underflows and never exceeds MAX_CREDIT. No wrap-around is possible.
- Reset mid-operation: dispense and change are abandoned, credit is lost, and all handshakes drop immediately (asynchronous).

Test Plan:
- Coins 10,10,01 (credit 5), sel=2 -> disp_req=1, disp_item=2, credit=0; disp_ack -> IDLE, no chg_req.
- Coins 10×4 (credit 8), sel=0 -> credit 5 after dispense; CHANGE emits chg_coin 10,10,01 across three chg_acks, then credit=0 and IDLE.
- Credit 2, sel=3 -> sel_error pulse, credit stays 2; sold_out[1]=1 with credit 8, sel=1 -> sel_error pulse; coin 11 -> coin_reject pulse.
- Credit 39 plus coin 10 -> coin_reject; coin during DISPENSE -> coin_reject, credit unchanged.
- Credit 6, sel=1, no disp_ack for TIMEOUT cycles -> fault pulse, credit back to 6, change paid as 10,10,10.
- Mid-CHANGE, drive rst=0 -> chg_req=0, credit=0 in the same cycle; after release, state is IDLE.
